param_calculator: RTL
=====================

// Module: param_calculator
// PURPOSE
//  Parametrised sequential calculator for the DE-board ALU lab. Debounces the
//  push-buttons, loads two WIDTH-bit operands from SW, runs a multi-op ALU
//  through a small FSM with a fixed 2-cycle latency, and drives a multi-digit
//  hex display and status LEDs.
// PARAMETERS
//  WIDTH            4       operand width in bits, legal range 1..8
//  DEBOUNCE_CYCLES  250000  stable-level cycles before a key change is accepted (5 ms @ 50 MHz)
//  HEX_DIGITS       4       number of 7-segment digits driven, legal range 1..4
// PORTS
//  CLOCK_50_B5B  in   1             system clock, 50 MHz
//  RST           in   1             asynchronous, active-high reset
//  SW            in   10            SW[WIDTH-1:0] operand, SW[9] view A/B, SW[8] B-not-A
//  KEY           in   3             active-low buttons: 0 load A, 1 load B, 2 execute
//  HEX           out  7*HEX_DIGITS  active-low segments; digit i = HEX[7*i+:7]
//  LEDR          out  10            status, see BEHAVIOUR
// BEHAVIOUR
//  Reset: clock and reset are fixed; reset is async, active-high, one clock.
//   All registers clear. Debounced key levels reset to 1. A=B=0, op=ADD, result=0,
//   flags=0, state=IDLE. HEX shows "0" on digit 0 and blank on the others. LEDR=0.
//   Reset mid-operation aborts CALC/DONE and returns the FSM to IDLE.
//  Key path, per key: 2-FF synchroniser, then a counter of DEBOUNCE_CYCLES.
//   - The debounced level changes only after the input differs for DEBOUNCE_CYCLES
//     consecutive cycles. Any bounce reloads the counter.
//   - A 1->0 transition of the debounced level gives a 1-cycle tick.
//  Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, (5 MUL, see CONFIGURATION).
//   The op register increments after each execute and wraps to 0 after the last op.
//  FSM:
//   IDLE: tick0 loads A<=SW[WIDTH-1:0]. tick1 loads B<=SW[WIDTH-1:0].
//         If tick0 and tick1 are simultaneous, both load.
//         tick2 has priority: loads in the same cycle are dropped. tick2 latches
//         opA/opB/op into pipeline registers and moves to CALC.
//   CALC: computes into a result register of width RES_W=2*WIDTH and moves to DONE.
//   DONE: updates flags and the visible result, advances op, returns to IDLE.
//   Latency: tick2 in cycle N -> result and flags visible in N+2.
//   busy = (state != IDLE). All ticks arriving while busy are ignored and lost.
//  Arithmetic, zero-extended to RES_W:
//   - ADD: result = A+B. carry = bit WIDTH.
//   - SUB: result = ({0,A}-{0,B}) masked to WIDTH+1 bits. carry = borrow = (A<B).
//   - Logic ops: WIDTH bits. carry = 0.
//   - zero flag = (result == 0).
//   - ovf flag = any result bit at position >= WIDTH is set.
//  Display:
//   - SW[9]=1 shows B if SW[8]=1, else A.
//   - SW[9]=0 shows the result.
//   - Hex value on digits 0..HEX_DIGITS-1 (value bits beyond 4*HEX_DIGITS are not shown).
//   - Leading digits above the most significant nonzero digit are blank (all 1s).
//     Digit 0 is never blank.
//  LEDR: [2:0] current op, [3] busy, [4] carry/borrow, [5] zero, [6] ovf, [9:7] = 0.
// CONFIGURATION
//  PARAM_CALCULATOR_MUL_EN defined:
//   - Adds op 5 MUL: result = A*B, full RES_W bits, carry = 0; the op wraps after 5.
//   - MUL is registered in CALC, so latency stays 2.
//  PARAM_CALCULATOR_MUL_EN undefined:
//   - No multiplier is built and the op wraps after 4 (XOR).
//   - An op value of 5 is unreachable.
// TESTING  (WIDTH=4, DEBOUNCE_CYCLES=4, HEX_DIGITS=4)
//  KEY0 bounces 1-0-1-0 every 2 cycles, then stays low 4+ cycles -> exactly one tick;
//   A loads SW=4'h3, LEDR[3:0] unaffected except op.
//  A=9, B=8, KEY2 at op=ADD -> N+2: result 8'h11, HEX shows "11" with digits 2-3 blank,
//   carry=1, ovf=1, op=1.
//  A=3, B=5, op=SUB -> result 5'h1E ("1E"), borrow=1; next op AND: A=F, B=F -> 8'h0F,
//   zero=0; then OR/XOR with A=B -> XOR result 0, zero=1, digit0 "0", op wraps to 0.
//  KEY0/KEY1 ticks during CALC/DONE are ignored (A, B unchanged).
//   tick2 and tick0 in the same IDLE cycle -> A unchanged, execute uses the old A.
//  RST asserted in CALC -> all outputs at reset values within the same cycle;
//   the FSM resumes in IDLE after release.
//  With MUL_EN: A=F, B=F, op=5 -> result 8'hE1, ovf=1, op wraps to 0.
//   Without MUL_EN: the op after XOR is ADD.

Source files
------------

// File: rtl/param_calculator.sv
// param_calculator: sequential ALU calculator for the DE-board lab.
//   Debounces three push-buttons, loads operands A/B from SW and executes one of
//   ADD/SUB/AND/OR/XOR (plus MUL when PARAM_CALCULATOR_MUL_EN is defined). Each
//   execute takes a fixed 2-cycle latency and then advances the op code.
// Ports:
//   CLOCK_50_B5B  system clock
//   RST           asynchronous, active-high reset
//   SW[9:0]       SW[WIDTH-1:0] operand, SW[9] view A/B, SW[8] selects B over A
//   KEY[2:0]      active-low buttons: 0 load A, 1 load B, 2 execute
//   HEX           active-low 7-segment digits, digit i = HEX[7*i+:7]
//   LEDR[9:0]     [2:0] op, [3] busy, [4] carry/borrow, [5] zero, [6] ovf
// Build option: PARAM_CALCULATOR_MUL_EN adds op 5 (MUL).
module param_calculator #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned HEX_DIGITS      = 4
) (
    input  logic                    CLOCK_50_B5B,
    input  logic                    RST,
    input  logic [9:0]              SW,
    input  logic [2:0]              KEY,
    output logic [7*HEX_DIGITS-1:0] HEX,
    output logic [9:0]              LEDR
);

    localparam int unsigned RES_W = 2 * WIDTH;
    localparam int unsigned HEX_W = 7 * HEX_DIGITS;
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
`ifdef PARAM_CALCULATOR_MUL_EN
    localparam logic [2:0] OP_MUL  = 3'd5;
    localparam logic [2:0] LAST_OP = OP_MUL;
`else
    localparam logic [2:0] LAST_OP = OP_XOR;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Active-low segment pattern (gfedcba) for one hex nibble.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    // Display after reset: "0" on digit 0, the rest blank.
    function automatic logic [HEX_W-1:0] hex_reset();
        logic [HEX_W-1:0] h;
        h      = '1;
        h[6:0] = 7'h40;
        return h;
    endfunction

    // ---------------- key synchronise + debounce ----------------
    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       level;
    logic [2:0]       tick;
    logic [CNT_W-1:0] cnt [3];

    // Level follows the synchronised key only after DEBOUNCE_CYCLES differing cycles.
    always_ff @(posedge CLOCK_50_B5B or posedge RST) begin
        if (RST) begin
            sync1 <= '1;
            sync2 <= '1;
            level <= '1;
            tick  <= '0;
            for (int k = 0; k < 3; k++) cnt[k] <= '0;
        end else begin
            sync1 <= KEY;
            sync2 <= sync1;
            for (int k = 0; k < 3; k++) begin
                tick[k] <= 1'b0;
                if (sync2[k] != level[k]) begin
                    if (cnt[k] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        level[k] <= sync2[k];
                        cnt[k]   <= '0;
                        tick[k]  <= level[k];   // only a 1->0 change ticks
                    end else begin
                        cnt[k] <= cnt[k] + CNT_W'(1);
                    end
                end else begin
                    cnt[k] <= '0;
                end
            end
        end
    end

    // ---------------- FSM and datapath ----------------
    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_q, a_nxt, b_q, b_nxt;
    logic [WIDTH-1:0]   opa_q, opa_nxt, opb_q, opb_nxt;
    logic [2:0]         op_q, op_nxt, opc_q, opc_nxt;
    logic [RES_W-1:0]   res_q, res_nxt;
    logic               carry_q, carry_nxt, zero_q, zero_nxt, ovf_q, ovf_nxt;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [RES_W-1:0]   alu_res;
    logic               alu_carry;

    // ALU on the latched pipeline operands.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        sum       = {1'b0, opa_q} + {1'b0, opb_q};
        diff      = {1'b0, opa_q} - {1'b0, opb_q};
        case (opc_q)
            OP_ADD: begin
                alu_res   = RES_W'(sum);
                alu_carry = sum[WIDTH];
            end
            OP_SUB: begin
                alu_res   = RES_W'(diff);
                alu_carry = (opa_q < opb_q);
            end
            OP_AND: alu_res = RES_W'(opa_q & opb_q);
            OP_OR:  alu_res = RES_W'(opa_q | opb_q);
            OP_XOR: alu_res = RES_W'(opa_q ^ opb_q);
`ifdef PARAM_CALCULATOR_MUL_EN
            OP_MUL: alu_res = RES_W'(opa_q) * RES_W'(opb_q);
`endif
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge CLOCK_50_B5B or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state plus next values of every datapath register. Results, flags and
    // the advanced op are written on leaving CALC, so they are visible in DONE.
    always_comb begin
        state_nxt = state;
        a_nxt     = a_q;
        b_nxt     = b_q;
        opa_nxt   = opa_q;
        opb_nxt   = opb_q;
        opc_nxt   = opc_q;
        op_nxt    = op_q;
        res_nxt   = res_q;
        carry_nxt = carry_q;
        zero_nxt  = zero_q;
        ovf_nxt   = ovf_q;
        case (state)
            S_IDLE: begin
                if (tick[2]) begin
                    opa_nxt   = a_q;
                    opb_nxt   = b_q;
                    opc_nxt   = op_q;
                    state_nxt = S_CALC;
                end else begin
                    if (tick[0]) a_nxt = SW[WIDTH-1:0];
                    if (tick[1]) b_nxt = SW[WIDTH-1:0];
                end
            end
            S_CALC: begin
                res_nxt   = alu_res;
                carry_nxt = alu_carry;
                zero_nxt  = (alu_res == '0);
                ovf_nxt   = |alu_res[RES_W-1:WIDTH];
                op_nxt    = (op_q == LAST_OP) ? 3'd0 : op_q + 3'd1;
                state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50_B5B or posedge RST) begin
        if (RST) begin
            a_q     <= '0;
            b_q     <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            opc_q   <= OP_ADD;
            op_q    <= OP_ADD;
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_nxt;
            b_q     <= b_nxt;
            opa_q   <= opa_nxt;
            opb_q   <= opb_nxt;
            opc_q   <= opc_nxt;
            op_q    <= op_nxt;
            res_q   <= res_nxt;
            carry_q <= carry_nxt;
            zero_q  <= zero_nxt;
            ovf_q   <= ovf_nxt;
        end
    end

    // ---------------- display and LEDs ----------------
    logic [RES_W-1:0] view;
    logic [15:0]      val16;
    logic [3:0]       nib;
    logic             lead;
    logic [HEX_W-1:0] hex_nxt;
    logic [9:0]       ledr_nxt;
    logic             unused_sw;

    assign unused_sw = ^SW;

    // Built from next-state values so the registered outputs track the registers.
    always_comb begin
        view  = SW[9] ? (SW[8] ? RES_W'(b_nxt) : RES_W'(a_nxt)) : res_nxt;
        val16 = 16'(view);
        lead  = 1'b1;
        nib   = '0;
        hex_nxt = '1;
        // Scan from the top digit down; blank until the first nonzero nibble.
        for (int i = int'(HEX_DIGITS) - 1; i >= 0; i--) begin
            nib = val16[4*i +: 4];
            if (nib != 4'h0) lead = 1'b0;
            hex_nxt[7*i +: 7] = (lead && (i != 0)) ? 7'h7F : seg7(nib);
        end
        ledr_nxt = {3'b000, ovf_nxt, zero_nxt, carry_nxt, (state_nxt != S_IDLE), op_nxt};
    end

    always_ff @(posedge CLOCK_50_B5B or posedge RST) begin
        if (RST) begin
            HEX  <= hex_reset();
            LEDR <= '0;
        end else begin
            HEX  <= hex_nxt;
            LEDR <= ledr_nxt;
        end
    end

endmodule
